// File: rtl/if1_pcgen_pkg.sv
// ---------------------------------------------------------------------------
// if1_pcgen_pkg
// Shared constants for the IF1 fetch-PC generator:
//   - FSM state encodings BOOT / RUN
//   - default reset PC, stall-bus width, branch-bus width
//   - IF1->IF2 bus width (grows by one bit when IF1_MISALIGN_CHK_EN is defined)
//   - dw_align(): force an address onto a 64-bit SRAM doubleword boundary
// ---------------------------------------------------------------------------
package if1_pcgen_pkg;

  localparam logic BOOT = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          STALL_BUS_WD = 6;
  localparam int          BR_BUS_WD    = 33;

`ifdef IF1_MISALIGN_CHK_EN
  localparam int IF12IF2_BUS_WD = 34;
`else
  localparam int IF12IF2_BUS_WD = 33;
`endif

  function automatic logic [31:0] dw_align(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/if1_pcgen.sv
// ---------------------------------------------------------------------------
// if1_pcgen -- first fetch stage of the in-order RV32I pipeline.
//
// Owns the fetch PC, chooses the next PC (flush > branch > pending branch >
// sequential +4) and issues synchronous doubleword reads to the instruction
// SRAM. The PC whose address was issued in cycle N appears on if12if2_bus in
// cycle N+1, together with the SRAM read data; IF2 selects the 32-bit half
// using pc[2].
//
// Optional feature macro: IF1_MISALIGN_CHK_EN
//   When defined, a PC with pc[1:0]!=0 is flagged by a registered
//   fetch_misalign bit carried as the MSB of if12if2_bus, and the SRAM read
//   for that PC is suppressed.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall[STALL_WD]   stall vector, bit 0 freezes IF1
//   flush, flush_pc   trap/exception redirect (highest priority)
//   br_bus[33]        {br_e, br_addr} from EX
//   inst_sram_*       read-only SRAM port (we/wdata tied to zero)
//   if12if2_bus       {[fetch_misalign,] pc_valid, pc} to IF2
// ---------------------------------------------------------------------------
module if1_pcgen
  import if1_pcgen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          STALL_WD   = STALL_BUS_WD,
  parameter int          IF12IF2_WD = IF12IF2_BUS_WD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STALL_WD-1:0]   stall,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  input  logic [BR_BUS_WD-1:0]  br_bus,
  output logic                  inst_sram_en,
  output logic [7:0]            inst_sram_we,
  output logic [31:0]           inst_sram_addr,
  output logic [63:0]           inst_sram_wdata,
  output logic [IF12IF2_WD-1:0] if12if2_bus
);

  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        state_q, state_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        br_e;
  logic [31:0] br_addr;
  logic        stall_if1;
  logic [31:0] next_pc;
  logic [31:0] fetch_pc;
  logic        accept;
  logic        en_raw;

  // Only bit 0 of the stall vector concerns IF1; the rest belong to later stages.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall[STALL_WD-1:1];

  assign br_e      = br_bus[32];
  assign br_addr   = br_bus[31:0];
  assign stall_if1 = stall[0];

  always_comb begin
    if (flush)         next_pc = flush_pc;
    else if (br_e)     next_pc = br_addr;
    else if (pend_v_q) next_pc = pend_pc_q;
    else               next_pc = pc_q + 32'd4;
  end

  always_comb begin
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    fetch_pc   = pc_q;
    accept     = 1'b0;

    case (state_q)
      BOOT: begin
        // Redirects are not meaningful before the first fetch is accepted.
        fetch_pc = RESET_PC;
        if (!stall_if1) begin
          pc_d       = RESET_PC;
          pc_valid_d = 1'b1;
          state_d    = RUN;
          accept     = 1'b1;
        end
      end
      default: begin
        // A flush wins even under stall, so the trap target is never lost.
        if (flush || !stall_if1) begin
          fetch_pc   = next_pc;
          pc_d       = next_pc;
          pc_valid_d = 1'b1;
          pend_v_d   = 1'b0;
          accept     = 1'b1;
        end else begin
          // Re-read the held PC so IF2 keeps seeing valid data while frozen;
          // a branch resolved now is remembered (newest wins) for the release.
          fetch_pc = pc_q;
          if (br_e) begin
            pend_v_d  = 1'b1;
            pend_pc_d = br_addr;
          end
        end
      end
    endcase
  end

`ifdef IF1_MISALIGN_CHK_EN
  logic fetch_misalign_q, fetch_misalign_d;

  always_comb begin
    fetch_misalign_d = fetch_misalign_q;
    if (accept) fetch_misalign_d = (fetch_pc[1:0] != 2'b00);
  end

  // Also covers the stalled re-read, where fetch_pc is the held PC.
  assign en_raw = (fetch_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_misalign_q <= 1'b0;
    else        fetch_misalign_q <= fetch_misalign_d;
  end

  assign if12if2_bus = {fetch_misalign_q, pc_valid_q, pc_q};
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign en_raw        = 1'b1;
  assign if12if2_bus   = {pc_valid_q, pc_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC - 32'd4;
      pc_valid_q <= 1'b0;
      state_q    <= BOOT;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign inst_sram_en    = rst_n & en_raw;
  assign inst_sram_addr  = dw_align(fetch_pc);
  assign inst_sram_we    = 8'h00;
  assign inst_sram_wdata = 64'd0;

endmodule
